// File: rtl/mem_read_responder.sv
// Word store with a fixed-latency read pipeline, write-wins collision handling,
// read-after-write forwarding and saturating request counters.
module mem_read_responder #(
  parameter int WIDTH        = 16,
  parameter int DEPTH_LOG2   = 5,
  parameter int READ_LATENCY = 2   // legal range 1..4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DEPTH_LOG2-1:0] Address,
  input  logic                  ReadEnable,
  input  logic                  WriteEnable,
  input  logic [WIDTH-1:0]      DataIn,
  output logic [WIDTH-1:0]      DataOut,
  output logic                  DataValid,
  output logic                  Collision,
  output logic [7:0]            ReadCount,
  output logic [7:0]            WriteCount
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem        [DEPTH];
  logic                  stage_vld  [READ_LATENCY];
  logic [DEPTH_LOG2-1:0] stage_addr [READ_LATENCY];
  logic [WIDTH-1:0]      stage_data [READ_LATENCY];

  logic rd_accept;
  assign rd_accept = ReadEnable & ~WriteEnable;

  // NOTE: the storage array is deliberately left out of reset so it maps onto
  // plain RAM; only the pipeline and counters are cleared.
  always_ff @(posedge Clock) begin
    if (Reset && WriteEnable)
      mem[Address] <= DataIn;
  end

  // NOTE: all state here uses <= so every stage samples its predecessor's
  // pre-edge value and the pipeline shifts by exactly one stage per clock.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_vld[i]  <= 1'b0;
        stage_addr[i] <= '0;
        stage_data[i] <= '0;
      end
      Collision  <= 1'b0;
      ReadCount  <= '0;
      WriteCount <= '0;
    end else begin
      Collision <= ReadEnable & WriteEnable;
      if (WriteEnable && WriteCount != 8'hFF)
        WriteCount <= WriteCount + 8'd1;
      if (rd_accept && ReadCount != 8'hFF)
        ReadCount <= ReadCount + 8'd1;

      // A read never coincides with a write here, so the array value is current.
      stage_vld[0] <= rd_accept;
      if (rd_accept) begin
        stage_addr[0] <= Address;
        stage_data[0] <= mem[Address];
      end

      // In-flight entries pick up any write to their address as they advance;
      // idle stages keep their data so DataOut holds between reads.
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_vld[i] <= stage_vld[i-1];
        if (stage_vld[i-1]) begin
          stage_addr[i] <= stage_addr[i-1];
          stage_data[i] <= (WriteEnable && Address == stage_addr[i-1]) ? DataIn
                                                                       : stage_data[i-1];
        end
      end
    end
  end

  assign DataOut   = stage_data[READ_LATENCY-1];
  assign DataValid = stage_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed plus randomized bench for mem_read_responder; a read returns the
// array contents as they stand when its data is delivered.
module tb_mem_read_responder;

  localparam int W   = 16;
  localparam int AW  = 5;
  localparam int LAT = 2;

  logic          Clock;
  logic          Reset;
  logic [AW-1:0] Address;
  logic          ReadEnable;
  logic          WriteEnable;
  logic [W-1:0]  DataIn;
  logic [W-1:0]  DataOut;
  logic          DataValid;
  logic          Collision;
  logic [7:0]    ReadCount;
  logic [7:0]    WriteCount;

  mem_read_responder #(
    .WIDTH(W), .DEPTH_LOG2(AW), .READ_LATENCY(LAT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Address(Address),
    .ReadEnable(ReadEnable), .WriteEnable(WriteEnable), .DataIn(DataIn),
    .DataOut(DataOut), .DataValid(DataValid), .Collision(Collision),
    .ReadCount(ReadCount), .WriteCount(WriteCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } req_t;

  // Reference state
  logic [W-1:0] ref_mem [1 << AW];
  req_t         pend [$];
  int           edge_n  = 0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_dout  = '0;
  logic         m_coll  = 1'b0;
  int           m_rc    = 0;
  int           m_wc    = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic rst, input logic re, input logic we,
                      input logic [AW-1:0] a, input logic [W-1:0] d);
    req_t r;
    Reset = rst; ReadEnable = re; WriteEnable = we; Address = a; DataIn = d;
    @(posedge Clock);
    edge_n++;
    if (!rst) begin
      pend.delete();
      m_valid = 1'b0; m_dout = '0; m_coll = 1'b0; m_rc = 0; m_wc = 0;
    end else begin
      m_coll = re & we;
      if (we) begin
        ref_mem[a] = d;
        if (m_wc < 255) m_wc++;
      end else if (re) begin
        if (m_rc < 255) m_rc++;
        pend.push_back('{addr: a, due: edge_n + LAT - 1});
      end
      m_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        r = pend.pop_front();
        m_valid = 1'b1;
        m_dout  = ref_mem[r.addr];
      end
    end
    #1;
    check("data_valid",  DataValid,  m_valid);
    check("data_out",    DataOut,    m_dout);
    check("collision",   Collision,  m_coll);
    check("read_count",  ReadCount,  m_rc);
    check("write_count", WriteCount, m_wc);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int            acc;
    logic [5:0]    idx;
    Reset = 1'b0; ReadEnable = 1'b0; WriteEnable = 1'b0; Address = '0; DataIn = '0;

    // Reset values
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 5'd4, '0);
    check("rst_dout",  DataOut, 0);
    check("rst_valid", DataValid, 0);
    check("rst_wc",    WriteCount, 0);
    idle();

    // Preload mem[i] = i+1
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b1, i[4:0], W'(i + 1));
    check("preload_wc", WriteCount, 32);

    // Single read of address 5
    step(1'b1, 1'b1, 1'b0, 5'd5, '0);
    idle();
    check("single_valid", DataValid, 1);
    check("single_dout",  DataOut, 6);
    idle();
    check("single_drop",  DataValid, 0);
    check("single_hold",  DataOut, 6);
    check("single_rc",    ReadCount, 1);

    // Controller sequence: SOLICITA_MEM, IDLE_1, LOAD, with SAVING writes
    acc = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b1, 1'b0, i[4:0], '0);
      idle();
      check("ctl_valid", DataValid, 1);
      check("ctl_load",  DataOut, i + 1);
      acc += i + 1;
      if (i == 8 || i == 16 || i == 24) step(1'b1, 1'b0, 1'b1, i[4:0], W'(acc));
      else idle();
    end
    idx = 6'd32;
    step(1'b1, 1'b0, 1'b1, idx[4:0], W'(acc));
    check("ctl_wc", WriteCount, 36);
    step(1'b1, 1'b1, 1'b0, 5'd0, '0);
    idle();
    check("ctl_readback", DataOut, 528);

    // Collision at address 3
    idle();
    step(1'b1, 1'b1, 1'b1, 5'd3, 16'hBEEF);
    check("coll_pulse", Collision, 1);
    check("coll_rc",    ReadCount, 34);
    idle();
    check("coll_clear", Collision, 0);
    check("coll_no_valid", DataValid, 0);
    step(1'b1, 1'b1, 1'b0, 5'd3, '0);
    idle();
    check("coll_mem", DataOut, 16'hBEEF);

    // Forwarding: read 7, then write 7 while the read is in flight
    step(1'b1, 1'b1, 1'b0, 5'd7, '0);
    step(1'b1, 1'b0, 1'b1, 5'd7, 16'h1234);
    check("fwd_valid", DataValid, 1);
    check("fwd_dout",  DataOut, 16'h1234);
    idle();

    // Reset mid-read
    step(1'b1, 1'b1, 1'b0, 5'd9, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    idle();
    check("rstmid_valid", DataValid, 0);
    idle();
    check("rstmid_after", DataValid, 0);

    // Read count saturation with held random reads
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, AW'($urandom_range(0, 31)), '0);
    check("rc_sat", ReadCount, 255);
    idle();
    idle();

    // Random mix of reads, writes and collisions
    for (int i = 0; i < 600; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 31)), W'($urandom));

    // Write count saturation
    for (int i = 0; i < 260; i++) step(1'b1, 1'b0, 1'b1, AW'($urandom_range(0, 31)), W'($urandom));
    check("wc_sat", WriteCount, 255);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_read_responder.md
# mem_read_responder

Memory-side responder for the accumulator controller's read/write strobes. It holds a 32-word data store and answers ReadEnable/Address requests with read data on a fixed latency, matched to the controller's SOLICITA_MEM → IDLE_1 → LOAD sequence. It also commits WriteEnable strobes, such as the partial sums written in the SAVING state. It sits between the controller/accumulator datapath and the storage array and also exposes request counters for debug.

## Interface

**Parameters**
- WIDTH, 16: data word width.
- DEPTH_LOG2, 5: address width; the array holds 2^DEPTH_LOG2 words.
- READ_LATENCY, 2: cycles from the first sampled read request to valid data. Legal values are 1 to 4.

**Ports**
- Clock, input, 1: single clock; all logic is on the rising edge.
- Reset, input, 1: synchronous, active-low reset.
- Address, input, DEPTH_LOG2: word address, used for both reads and writes.
- ReadEnable, input, 1: read request, level-sensitive.
- WriteEnable, input, 1: write strobe; one word is written per cycle while high.
- DataIn, input, WIDTH: write data.
- DataOut, output, WIDTH: read data, registered.
- DataValid, output, 1: DataOut holds data for a sampled request.
- Collision, output, 1: one-cycle pulse when ReadEnable and WriteEnable were high in the same cycle.
- ReadCount, output, 8: number of accepted read cycles; saturates at 255.
- WriteCount, output, 8: number of committed writes; saturates at 255.

## Operation

**Storage**
- The array has 2^DEPTH_LOG2 words of WIDTH bits.
- Reset does not touch array contents.

**Read pipeline**
- The pipeline has READ_LATENCY stages.
- Stage 1 registers {valid, Address} whenever ReadEnable is high and WriteEnable is low.
- The final stage registers mem[addr] into DataOut and asserts DataValid.
- Stages in between only carry the valid bit and the data.
- The pipeline accepts a new read every cycle. Held requests, with ReadEnable high for several cycles, produce a new DataOut every cycle.

**Hold behaviour**
- With no read in the pipeline, DataOut holds its last value.
- DataValid is 0 in that case.

**Write**
- When WriteEnable is high, mem[Address] is set to DataIn at the rising edge.
- WriteCount increments by 1 and saturates at 255.

**Read/write in the same cycle**
- The write wins: the write is committed and the read is dropped.
- No pipeline entry is created for the dropped read.
- Collision is high in the next cycle only.
- ReadCount does not increment.

**Read-after-write forwarding**
- If a write to address A commits while a read of A is in flight in any pipeline stage, that read returns the newly written DataIn.
- This applies to a write in the same cycle as the array access or earlier.
- Forwarding is mandatory. The controller never depends on it, but the bench checks it.

**Address range**
- Address is exactly DEPTH_LOG2 bits wide.
- The controller's 6-bit index wraps: index 32 maps to address 0, and no error is raised.

**Counters**
- ReadCount counts cycles with ReadEnable high and WriteEnable low.
- Both counters saturate at 255 and clear only on reset.

## Timing

**Reset**
- While Reset is low at a rising edge, all pipeline valid bits clear.
- DataOut = 0, DataValid = 0, Collision = 0, ReadCount = 0, WriteCount = 0.
- Requests sampled in that cycle are ignored.
- Reset asserted mid-read discards the in-flight read: DataValid stays 0 afterwards.

**Read latency**
- A request sampled in cycle t gives DataOut and DataValid valid in cycle t+READ_LATENCY.
- With the default latency of 2, a request in SOLICITA_MEM (t) gives data valid in LOAD (t+2), where Load captures it.
- A request held over cycles t..t+2 gives DataValid high in cycles t+2..t+4.
- DataOut is mem[addr(t+k-2)] in cycle t+k.

**Write timing**
- A write is visible to a new read request issued in the cycle after the write.
- That read returns the new data READ_LATENCY cycles later.

**Combinational paths**
- There are no combinational paths from inputs to outputs.

## Test plan

- **Reset values:** after reset, DataOut=0, DataValid=0, Collision=0, ReadCount=0, WriteCount=0. Then preload mem[i]=i+1 for i=0..31 with writes; WriteCount must read 32.
- **Single read:** ReadEnable high for one cycle at Address=5 (t) → DataOut=6 and DataValid=1 in t+2, DataValid=0 in t+3. ReadCount=1.
- **Controller sequence:** full 32-read/4-write controller sequence run against the preloaded array → the accumulator captures 1..32 in LOAD. The writes land at addresses 8, 16, 24 and 0 (wrap). Readback of address 0 returns the last sum.
- **Collision:** ReadEnable=WriteEnable=1 at Address=3 with DataIn=0xBEEF → mem[3]=0xBEEF, Collision=1 for one cycle, no DataValid two cycles later, ReadCount unchanged.
- **Forwarding:** read Address=7 in cycle t, then write Address=7 with DataIn=0x1234 in cycle t+1 → DataOut=0x1234 in t+2.
- **Reset mid-read and saturation:** a read in cycle t with Reset low in t+1 → DataValid=0 in t+2. Separately, 300 held read cycles → ReadCount=255.
